// File: rtl/cic_decim_pkg.sv
// Shared receiver constants for the CIC decimator and the saturate/round stage it feeds.
// Holds the default geometry and the accumulator width legality rule.
package cic_decim_pkg;

    localparam int unsigned CIC_IN_SIZE  = 16;
    localparam int unsigned CIC_STAGES   = 3;
    localparam int unsigned CIC_DEC_RATE = 32;
    localparam int unsigned CIC_ACC_SIZE = 34;

    // Bit growth of an N-stage, M=1 CIC decimating by R is N*ceil(log2(R)).
    function automatic int unsigned cic_min_acc(
        input int unsigned in_size,
        input int unsigned stages,
        input int unsigned dec_rate
    );
        return in_size + stages * $clog2(dec_rate);
    endfunction

    function automatic bit cic_cfg_ok(
        input int unsigned in_size,
        input int unsigned stages,
        input int unsigned dec_rate,
        input int unsigned acc_size
    );
        return (stages >= 1) && (stages <= 5) &&
               (dec_rate >= stages + 1) && (dec_rate <= 64) &&
               (acc_size >= cic_min_acc(in_size, stages, dec_rate));
    endfunction

    // Width of the downstream saturate/round input, which takes q1/q2 unmodified.
    localparam int unsigned CIC_SAT_IN_SIZE = CIC_ACC_SIZE;

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb (y = x - x_prev) for both I/Q channels, advanced only on the decimation token.
// The token is delayed alongside the data so the chain carries its own strobe.
module cic_comb_stage
    import cic_decim_pkg::*;
#(
    parameter int unsigned WIDTH = CIC_ACC_SIZE
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sync,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x1,
    input  logic signed [WIDTH-1:0] x2,
    output logic                    tok,
    output logic signed [WIDTH-1:0] y1,
    output logic signed [WIDTH-1:0] y2
);

    logic signed [WIDTH-1:0] prev1;
    logic signed [WIDTH-1:0] prev2;

    // sync leaves y untouched so the last published output holds until the next strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tok   <= 1'b0;
            prev1 <= '0;
            prev2 <= '0;
            y1    <= '0;
            y2    <= '0;
        end else if (sync) begin
            tok   <= 1'b0;
            prev1 <= '0;
            prev2 <= '0;
        end else begin
            tok <= en;
            if (en) begin
                y1    <= x1 - prev1;
                y2    <= x2 - prev2;
                prev1 <= x1;
                prev2 <= x2;
            end
        end
    end

endmodule

// File: rtl/cic_decim.sv
// Two-channel (I/Q) CIC decimator: STAGES integrators at input rate, STAGES combs at output rate.
// All arithmetic wraps modulo 2^ACC_SIZE; out_valid is a single-cycle push with no backpressure.
module cic_decim
    import cic_decim_pkg::*;
#(
    parameter int unsigned IN_SIZE  = CIC_IN_SIZE,
    parameter int unsigned STAGES   = CIC_STAGES,
    parameter int unsigned DEC_RATE = CIC_DEC_RATE,
    parameter int unsigned ACC_SIZE = CIC_ACC_SIZE
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sync,
    input  logic                       in_valid,
    input  logic signed [IN_SIZE-1:0]  d1,
    input  logic signed [IN_SIZE-1:0]  d2,
    output logic                       out_valid,
    output logic signed [ACC_SIZE-1:0] q1,
    output logic signed [ACC_SIZE-1:0] q2
);

    localparam int unsigned PW = $clog2(DEC_RATE);

    if (!cic_cfg_ok(IN_SIZE, STAGES, DEC_RATE, ACC_SIZE)) begin : g_bad_cfg
        $error("cic_decim: illegal IN_SIZE/STAGES/DEC_RATE/ACC_SIZE combination");
    end

    logic signed [ACC_SIZE-1:0] x1;
    logic signed [ACC_SIZE-1:0] x2;
    logic [PW-1:0]              phase;
    logic                       phase_last;
    logic                       tok_int;
    logic                       tok_samp;
    logic signed [ACC_SIZE-1:0] samp1;
    logic signed [ACC_SIZE-1:0] samp2;

    assign x1         = ACC_SIZE'(d1);
    assign x2         = ACC_SIZE'(d2);
    assign phase_last = (phase == PW'(DEC_RATE - 1));

    // Phase counter and decimation token, shared by both channels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            tok_int <= 1'b0;
        end else if (sync) begin
            phase   <= '0;
            tok_int <= 1'b0;
        end else begin
            tok_int <= in_valid && phase_last;
            if (in_valid) begin
                phase <= phase_last ? '0 : phase + PW'(1);
            end
        end
    end

    // Each integrator adds the previous stage's registered value, so the chain is pipelined.
    for (genvar g = 0; g < STAGES; g++) begin : g_integ
        logic signed [ACC_SIZE-1:0] feed1;
        logic signed [ACC_SIZE-1:0] feed2;
        logic signed [ACC_SIZE-1:0] acc1;
        logic signed [ACC_SIZE-1:0] acc2;

        if (g == 0) begin : g_first
            assign feed1 = x1;
            assign feed2 = x2;
        end else begin : g_next
            assign feed1 = g_integ[g-1].acc1;
            assign feed2 = g_integ[g-1].acc2;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc1 <= '0;
                acc2 <= '0;
            end else if (sync) begin
                acc1 <= '0;
                acc2 <= '0;
            end else if (in_valid) begin
                acc1 <= acc1 + feed1;
                acc2 <= acc2 + feed2;
            end
        end
    end

    // The last integrator is captured the cycle after the token, i.e. including the token sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tok_samp <= 1'b0;
            samp1    <= '0;
            samp2    <= '0;
        end else if (sync) begin
            tok_samp <= 1'b0;
            samp1    <= '0;
            samp2    <= '0;
        end else begin
            tok_samp <= tok_int;
            if (tok_int) begin
                samp1 <= g_integ[STAGES-1].acc1;
                samp2 <= g_integ[STAGES-1].acc2;
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        logic                       en;
        logic signed [ACC_SIZE-1:0] x1c;
        logic signed [ACC_SIZE-1:0] x2c;
        logic                       tok;
        logic signed [ACC_SIZE-1:0] y1;
        logic signed [ACC_SIZE-1:0] y2;

        if (g == 0) begin : g_first
            assign en  = tok_samp;
            assign x1c = samp1;
            assign x2c = samp2;
        end else begin : g_next
            assign en  = g_comb[g-1].tok;
            assign x1c = g_comb[g-1].y1;
            assign x2c = g_comb[g-1].y2;
        end

        cic_comb_stage #(
            .WIDTH (ACC_SIZE)
        ) u_comb (
            .clk     (clk),
            .reset_n (reset_n),
            .sync    (sync),
            .en      (en),
            .x1      (x1c),
            .x2      (x2c),
            .tok     (tok),
            .y1      (y1),
            .y2      (y2)
        );
    end

    assign out_valid = g_comb[STAGES-1].tok;
    assign q1        = g_comb[STAGES-1].y1;
    assign q2        = g_comb[STAGES-1].y2;

endmodule

// File: tb/tb_cic_decim.sv
// Scoreboard bench for cic_decim: stimulus queues expected strobes, a negedge monitor checks them.
// Expected values come from the zero-state step response of a 3-stage R=32 CIC: 4960, 26784, 32768...
module tb_cic_decim;

    localparam int IN_SIZE  = 16;
    localparam int STAGES   = 3;
    localparam int DEC_RATE = 32;
    localparam int ACC_SIZE = 34;
    localparam int LAT      = STAGES + 2;

    logic                       clk      = 1'b0;
    logic                       reset_n  = 1'b0;
    logic                       sync     = 1'b0;
    logic                       in_valid = 1'b0;
    logic signed [IN_SIZE-1:0]  d1       = '0;
    logic signed [IN_SIZE-1:0]  d2       = '0;
    logic                       out_valid;
    logic signed [ACC_SIZE-1:0] q1;
    logic signed [ACC_SIZE-1:0] q2;

    cic_decim #(
        .IN_SIZE  (IN_SIZE),
        .STAGES   (STAGES),
        .DEC_RATE (DEC_RATE),
        .ACC_SIZE (ACC_SIZE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync      (sync),
        .in_valid  (in_valid),
        .d1        (d1),
        .d2        (d2),
        .out_valid (out_valid),
        .q1        (q1),
        .q2        (q2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                         cyc;
        logic signed [ACC_SIZE-1:0] e1;
        logic signed [ACC_SIZE-1:0] e2;
    } exp_t;

    exp_t   sb[$];
    int     total   = 0;
    int     bad     = 0;
    int     nstrobe = 0;
    int     phase   = 0;
    int     grp     = 0;
    longint tab[3]  = '{64'sd4960, 64'sd26784, 64'sd32768};

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            nstrobe++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("q1", q1, e.e1);
                check("q2", q2, e.e2);
            end
        end
    end

    task automatic push_token(input logic signed [IN_SIZE-1:0] a, input logic signed [IN_SIZE-1:0] b);
        exp_t e;
        int   idx;
        idx   = (grp < 3) ? grp : 2;
        e.cyc = cyc + LAT;
        e.e1  = ACC_SIZE'(longint'(a) * tab[idx]);
        e.e2  = ACC_SIZE'(longint'(b) * tab[idx]);
        sb.push_back(e);
        grp++;
    endtask

    task automatic sample(input bit v, input logic signed [IN_SIZE-1:0] a, input logic signed [IN_SIZE-1:0] b);
        @(posedge clk);
        #1;
        in_valid = v;
        d1       = a;
        d2       = b;
        if (v) begin
            if (phase == DEC_RATE - 1) push_token(a, b);
            phase = (phase + 1) % DEC_RATE;
        end
    endtask

    task automatic run(input int n, input logic signed [IN_SIZE-1:0] a, input logic signed [IN_SIZE-1:0] b);
        for (int i = 0; i < n; i++) sample(1'b1, a, b);
    endtask

    task automatic drop_after(input int lim);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc > lim) sb.delete(i);
    endtask

    task automatic do_sync(input bit v);
        @(posedge clk);
        #1;
        sync     = 1'b1;
        in_valid = v;
        d1       = 16'sd100;
        d2       = -16'sd100;
        drop_after(cyc);
        @(posedge clk);
        #1;
        sync     = 1'b0;
        in_valid = 1'b0;
        phase    = 0;
        grp      = 0;
    endtask

    task automatic drain(input string name);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        check(name, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nvalid;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_q1", q1, 0);
        check("reset_q2", q2, 0);
        reset_n = 1'b1;

        // DC, gap-free
        base = nstrobe;
        run(10 * DEC_RATE, 16'sd1, -16'sd1);
        drain("dc_drain");
        check("dc_strobes", nstrobe - base, 10);
        check("dc_q1_steady", q1, 32768);
        check("dc_q2_steady", q2, -32768);

        // Full scale: integrators wrap many times over
        do_sync(1'b0);
        run(8 * DEC_RATE, -16'sd32768, 16'sd32767);
        drain("fs_drain");
        check("fs_q1_steady", q1, -1073741824);
        check("fs_q2_steady", q2, 1073709056);

        // 30% duty input gaps
        do_sync(1'b0);
        base   = nstrobe;
        nvalid = 0;
        while (nvalid < 10 * DEC_RATE) begin
            bit v;
            v = ($urandom_range(0, 9) < 3);
            sample(v, 16'sd1, -16'sd1);
            if (v) nvalid++;
        end
        drain("gap_drain");
        check("gap_strobes", nstrobe - base, 10);
        check("gap_q1_steady", q1, 32768);

        // sync with a token in flight; the sample presented with sync is discarded
        do_sync(1'b0);
        run(DEC_RATE, 16'sd2, 16'sd2);
        run(2, 16'sd2, 16'sd2);
        base = nstrobe;
        do_sync(1'b1);
        repeat (LAT + 3) @(posedge clk);
        check("inflight_suppressed", nstrobe - base, 0);
        run(2 * DEC_RATE, 16'sd2, -16'sd3);
        drain("post_sync_drain");

        // sync at sample 17 of a group
        run(17, 16'sd3, -16'sd5);
        do_sync(1'b1);
        base = nstrobe;
        run(DEC_RATE, 16'sd3, -16'sd5);
        drain("sync17_drain");
        check("sync17_strobes", nstrobe - base, 1);
        check("sync17_q1", q1, 14880);
        check("sync17_q2", q2, -24800);

        // Asynchronous reset mid-group
        do_sync(1'b0);
        run(DEC_RATE + 8, 16'sd2, -16'sd2);
        check("prereset_q1", q1, 9920);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        drop_after(cyc - 1);
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_q1", q1, 0);
        check("rst_async_q2", q2, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        phase   = 0;
        grp     = 0;
        base    = nstrobe;
        run(2 * DEC_RATE, 16'sd7, -16'sd1);
        drain("postreset_drain");
        check("postreset_strobes", nstrobe - base, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
